// File: rtl/eth_crc_pkg.sv
// Shared CRC-32 constants, types and the reflected byte-step function used by the stream engine.

package eth_crc_pkg;

    typedef logic [31:0] crc32_t;

    typedef enum logic {StIdle, StActive} crc_state_e;

    localparam crc32_t CRC32_POLY_R  = 32'hEDB88320;
    localparam crc32_t CRC32_INIT    = 32'hFFFFFFFF;
    localparam crc32_t CRC32_XOR_OUT = 32'hFFFFFFFF;
    localparam crc32_t CRC32_RESIDUE = 32'hDEBB20E3;

    // Reflected update: the state shifts right and data enters LSB first.
    function automatic crc32_t crc32_byte(input crc32_t state, input logic [7:0] data,
                                          input crc32_t poly = CRC32_POLY_R);
        crc32_t s;
        s = state;
        for (int i = 0; i < 8; i++) begin
            s = (s >> 1) ^ (poly & {32{s[0] ^ data[i]}});
        end
        return s;
    endfunction

endpackage

// File: rtl/eth_crc32_lanes.sv
// Combinational chain of per-lane CRC byte steps; partial_o[k] is the state after k lanes.

module eth_crc32_lanes
    import eth_crc_pkg::*;
#(
    parameter int unsigned NB     = 1,
    parameter crc32_t      POLY_R = CRC32_POLY_R
) (
    input  crc32_t            state_i,
    input  logic [8*NB-1:0]   data_i,
    output crc32_t            partial_o [NB+1]
);

    crc32_t s;

    always_comb begin
        s            = state_i;
        partial_o[0] = s;
        for (int k = 0; k < NB; k++) begin
            s              = crc32_byte(s, data_i[8*k +: 8], POLY_R);
            partial_o[k+1] = s;
        end
    end

endmodule

// File: rtl/eth_crc32_stream.sv
// Frame-aware CRC-32 engine: folds DATA_W-bit beats, emits a registered FCS/check result after eof.

module eth_crc32_stream
    import eth_crc_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter crc32_t      POLY_R  = CRC32_POLY_R,
    parameter crc32_t      INIT    = CRC32_INIT,
    parameter crc32_t      XOR_OUT = CRC32_XOR_OUT,
    parameter crc32_t      RESIDUE = CRC32_RESIDUE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic                  in_eof,
    input  logic [DATA_W/8-1:0]   in_keep,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_chk,
    output logic [31:0]           crc_state,
    output logic                  busy,
    output logic                  res_valid,
    output logic [31:0]           fcs_out,
    output logic                  fcs_ok,
    output logic                  proto_err
);

    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned CntW = $clog2(NB + 1);

    crc_state_e      state_q;
    crc32_t          crc_q;
    crc32_t          fcs_q;
    logic            fcs_ok_q;
    logic            res_valid_q;
    logic            proto_err_q;

    crc32_t          seed;
    crc32_t          crc_next;
    crc32_t          partial [NB+1];
    logic [CntW-1:0] fold_cnt;
    logic            run;

    // A sof beat always restarts from INIT, whether the engine was idle or mid-frame.
    assign seed = in_sof ? INIT : crc_q;

    eth_crc32_lanes #(
        .NB     (NB),
        .POLY_R (POLY_R)
    ) u_lanes (
        .state_i   (seed),
        .data_i    (in_data),
        .partial_o (partial)
    );

    // Only the contiguous keep run starting at lane 0 counts on an eof beat.
    always_comb begin
        fold_cnt = CntW'(NB);
        run      = 1'b1;
        if (in_eof) begin
            fold_cnt = '0;
            for (int k = 0; k < NB; k++) begin
                if (run && in_keep[k]) begin
                    fold_cnt = fold_cnt + CntW'(1);
                end else begin
                    run = 1'b0;
                end
            end
        end
    end

    assign crc_next = partial[fold_cnt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            crc_q       <= INIT;
            fcs_q       <= '0;
            fcs_ok_q    <= 1'b0;
            res_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    StIdle: begin
                        if (in_sof) begin
                            crc_q <= crc_next;
                            if (in_eof) begin
                                res_valid_q <= 1'b1;
                                fcs_q       <= crc_next ^ XOR_OUT;
                                fcs_ok_q    <= in_chk && (crc_next == RESIDUE);
                            end else begin
                                state_q <= StActive;
                            end
                        end else begin
                            proto_err_q <= 1'b1;
                        end
                    end
                    StActive: begin
                        crc_q <= crc_next;
                        if (in_sof) begin
                            proto_err_q <= 1'b1;
                        end
                        if (in_eof) begin
                            res_valid_q <= 1'b1;
                            fcs_q       <= crc_next ^ XOR_OUT;
                            fcs_ok_q    <= in_chk && (crc_next == RESIDUE);
                            state_q     <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign crc_state = crc_q;
    assign busy      = (state_q == StActive);
    assign res_valid = res_valid_q;
    assign fcs_out   = fcs_q;
    assign fcs_ok    = fcs_ok_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_eth_crc32_stream.sv
// Bench for eth_crc32_stream at DATA_W 8/32/64 against a bytewise CRC-32 reference model.

module tb_eth_crc32_stream;

    typedef logic [7:0] byte_t;

    localparam logic [31:0] RES = 32'hDEBB20E3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        vld [3];
    logic        sof [3];
    logic        eof [3];
    logic        chk [3];
    logic [63:0] dat [3];
    logic [7:0]  kp  [3];

    logic [31:0] crc_st [3];
    logic [31:0] fcs    [3];
    logic        busy   [3];
    logic        rv     [3];
    logic        ok     [3];
    logic        perr   [3];

    int  n_vec = 0;
    int  n_mis = 0;
    bit  gaps  = 0;

    eth_crc32_stream #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_sof(sof[0]), .in_eof(eof[0]),
        .in_keep(kp[0][0:0]), .in_data(dat[0][7:0]), .in_chk(chk[0]),
        .crc_state(crc_st[0]), .busy(busy[0]), .res_valid(rv[0]), .fcs_out(fcs[0]),
        .fcs_ok(ok[0]), .proto_err(perr[0])
    );

    eth_crc32_stream #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_sof(sof[1]), .in_eof(eof[1]),
        .in_keep(kp[1][3:0]), .in_data(dat[1][31:0]), .in_chk(chk[1]),
        .crc_state(crc_st[1]), .busy(busy[1]), .res_valid(rv[1]), .fcs_out(fcs[1]),
        .fcs_ok(ok[1]), .proto_err(perr[1])
    );

    eth_crc32_stream #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_sof(sof[2]), .in_eof(eof[2]),
        .in_keep(kp[2]), .in_data(dat[2]), .in_chk(chk[2]),
        .crc_state(crc_st[2]), .busy(busy[2]), .res_valid(rv[2]), .fcs_out(fcs[2]),
        .fcs_ok(ok[2]), .proto_err(perr[2])
    );

    // Textbook reflected CRC-32 over a byte list; returns the raw (uncomplemented) register.
    function automatic logic [31:0] ref_raw(input byte_t q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
                else      c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic int nb_of(input int u);
        return (u == 0) ? 1 : (u == 1) ? 4 : 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int u, input string tag);
        check({tag, " crc_state"}, crc_st[u], 32'hFFFFFFFF);
        check({tag, " busy"},      32'(busy[u]), 32'd0);
        check({tag, " res_valid"}, 32'(rv[u]), 32'd0);
        check({tag, " fcs_out"},   fcs[u], 32'd0);
        check({tag, " fcs_ok"},    32'(ok[u]), 32'd0);
        check({tag, " proto_err"}, 32'(perr[u]), 32'd0);
    endtask

    task automatic check_result(input int u, input string tag, input byte_t q[$], input bit c);
        logic [31:0] raw;
        raw = ref_raw(q);
        check({tag, " res_valid"}, 32'(rv[u]), 32'd1);
        check({tag, " fcs_out"},   fcs[u], ~raw);
        check({tag, " fcs_ok"},    32'(ok[u]), 32'(c && (raw == RES)));
        check({tag, " crc_state"}, crc_st[u], raw);
        check({tag, " busy"},      32'(busy[u]), 32'd0);
    endtask

    // Drives one frame (or frame fragment); returns at the negedge after its last beat.
    task automatic send(input int u, input byte_t q[$], input bit c, input bit do_sof,
                        input bit do_eof);
        int nb;
        int len;
        int beats;
        int rem;
        bit last;
        logic [63:0] d;
        logic [7:0] k;
        nb    = nb_of(u);
        len   = q.size();
        beats = (len == 0) ? 1 : (len + nb - 1) / nb;
        for (int b = 0; b < beats; b++) begin
            if (gaps && b > 0 && $urandom_range(0, 3) == 0) begin
                vld[u] = 1'b0;
                sof[u] = 1'($urandom);
                eof[u] = 1'($urandom);
                dat[u] = {$urandom, $urandom};
                @(negedge clk);
            end
            last = (b == beats - 1);
            d    = {$urandom, $urandom};
            k    = 8'($urandom);
            for (int l = 0; l < nb; l++) begin
                if (b * nb + l < len) d[8*l +: 8] = q[b * nb + l];
            end
            if (last && do_eof) begin
                rem = len - b * nb;
                if (rem > nb) rem = nb;
                k = 8'(($urandom & ~((1 << (rem + 1)) - 1)) | ((1 << rem) - 1));
            end
            vld[u] = 1'b1;
            sof[u] = do_sof && (b == 0);
            eof[u] = last && do_eof;
            chk[u] = last ? c : 1'($urandom);
            dat[u] = d;
            kp[u]  = k;
            @(negedge clk);
            check("beat proto_err", 32'(perr[u]), 32'd0);
            if (!(last && do_eof)) begin
                check("beat res_valid", 32'(rv[u]), 32'd0);
                check("beat busy", 32'(busy[u]), 32'd1);
            end
        end
        vld[u] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            for (int u = 0; u < 3; u++) vld[u] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        byte_t s9[$];
        byte_t q[$];
        byte_t f[$];
        logic [31:0] raw;
        logic [31:0] prev;
        bit c;
        int len;

        for (int u = 0; u < 3; u++) begin
            vld[u] = 1'b0; sof[u] = 1'b0; eof[u] = 1'b0; chk[u] = 1'b0;
            dat[u] = '0;   kp[u]  = '0;
        end
        for (int i = 0; i < 9; i++) s9.push_back(8'(8'h31 + i));

        @(negedge clk);
        for (int u = 0; u < 3; u++) check_reset(u, "reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // T1: 8-bit beats, generate mode, result one cycle after eof and then held
        send(0, s9, 1'b0, 1'b1, 1'b1);
        check_result(0, "T1", s9, 1'b0);
        check("T1 fcs const", fcs[0], 32'hCBF43926);
        idle(1);
        check("T1 pulse end", 32'(rv[0]), 32'd0);
        check("T1 fcs held", fcs[0], 32'hCBF43926);

        // T2: wide datapaths with a partial last beat
        send(1, s9, 1'b0, 1'b1, 1'b1);
        check_result(1, "T2w32", s9, 1'b0);
        check("T2w32 fcs const", fcs[1], 32'hCBF43926);
        send(2, s9, 1'b0, 1'b1, 1'b1);
        check_result(2, "T2w64", s9, 1'b0);
        check("T2w64 fcs const", fcs[2], 32'hCBF43926);
        idle(1);

        // T3: check mode, good then corrupted
        q = s9;
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        send(0, q, 1'b1, 1'b1, 1'b1);
        check_result(0, "T3good", q, 1'b1);
        check("T3 ok const", 32'(ok[0]), 32'd1);
        check("T3 residue const", crc_st[0], 32'hDEBB20E3);
        q[1] = q[1] ^ 8'h01;
        send(0, q, 1'b1, 1'b1, 1'b1);
        check_result(0, "T3bad", q, 1'b1);
        check("T3 bad ok const", 32'(ok[0]), 32'd0);

        // T4: single-beat frame then T1 frame back to back
        q = {8'h00};
        send(0, q, 1'b0, 1'b1, 1'b1);
        check_result(0, "T4single", q, 1'b0);
        check("T4 fcs const", fcs[0], 32'hD202EF8D);
        send(0, s9, 1'b0, 1'b1, 1'b1);
        check_result(0, "T4b2b", s9, 1'b0);
        idle(1);

        // T5a: beat without sof in IDLE is dropped
        prev   = crc_st[0];
        vld[0] = 1'b1; sof[0] = 1'b0; eof[0] = 1'b1; dat[0] = 64'(8'hA5); kp[0] = 8'h01;
        @(negedge clk);
        vld[0] = 1'b0;
        check("T5a proto_err", 32'(perr[0]), 32'd1);
        check("T5a res_valid", 32'(rv[0]), 32'd0);
        check("T5a state held", crc_st[0], prev);
        check("T5a busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        check("T5a pulse end", 32'(perr[0]), 32'd0);

        // T5b: sof mid-frame abandons the old frame
        q = {8'h41, 8'h42, 8'h43};
        send(0, q, 1'b0, 1'b1, 1'b0);
        vld[0] = 1'b1; sof[0] = 1'b1; eof[0] = 1'b0; dat[0] = 64'(s9[0]);
        @(negedge clk);
        check("T5b proto_err", 32'(perr[0]), 32'd1);
        check("T5b res_valid", 32'(rv[0]), 32'd0);
        q = s9[1:8];
        send(0, q, 1'b0, 1'b0, 1'b1);
        check_result(0, "T5b", s9, 1'b0);

        // T6: async reset during beat 4 of T1, then rerun
        q = s9[0:2];
        send(0, q, 1'b0, 1'b1, 1'b0);
        vld[0] = 1'b1; sof[0] = 1'b0; eof[0] = 1'b0; dat[0] = 64'(s9[3]);
        rst = 1'b1;
        #1;
        check_reset(0, "T6 in reset");
        @(negedge clk);
        rst    = 1'b0;
        vld[0] = 1'b0;
        @(negedge clk);
        check_reset(0, "T6 after reset");
        send(0, s9, 1'b0, 1'b1, 1'b1);
        check_result(0, "T6 rerun", s9, 1'b0);
        idle(1);

        // Random frames on every width, with gaps, garbage keep bits and check-mode FCS
        gaps = 1;
        for (int u = 0; u < 3; u++) begin
            for (int n = 0; n < 10; n++) begin
                len = $urandom_range(0, 20);
                c   = 1'($urandom);
                f   = {};
                for (int i = 0; i < len; i++) f.push_back(8'($urandom));
                if (c) begin
                    raw = ~ref_raw(f);
                    for (int i = 0; i < 4; i++) f.push_back(raw[8*i +: 8]);
                    if ($urandom_range(0, 2) == 0) begin
                        len    = $urandom_range(0, f.size() - 1);
                        f[len] = f[len] ^ 8'(1 << $urandom_range(0, 7));
                    end
                end
                send(u, f, c, 1'b1, 1'b1);
                check_result(u, "rand", f, c);
                idle($urandom_range(0, 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
